l2_req_arbiter: RTL and testbench

//  Shares the single L2 cache port between the I-cache and D-cache miss/write-back paths.

---
 rtl/l2_req_arbiter.sv | 97 +++++++++
 tb/tb_l2_req_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: round-robin arbiter sharing one L2 port between I-cache and D-cache
// Ports:
//   clk, rst (async, active-low)
//   i_ren/i_addr -> i_rdata/i_ready          : I-cache line read request and response
//   d_ren/d_wen/d_addr/d_wdata -> d_rdata/d_ready : D-cache read/write-back request and response
//   l2_ren/l2_wen/l2_addr/l2_wdata <- l2_rdata/l2_ready : shared L2 port
//   i_grant_cnt/d_grant_cnt : completed transactions, saturating
//   i_wait_cnt/d_wait_cnt   : cycles spent waiting while the other side is busy, saturating
module l2_req_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              l2_ren,
  output logic              l2_wen,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_ready,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  i_wait_cnt,
  output logic [CNT_W-1:0]  d_wait_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t state_q;
  logic   last_d_q;
  logic   d_req;
  logic   d_wins;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  assign d_req  = d_ren | d_wen;
  // D wins when it is the only requester, or on a tie when I was granted last
  assign d_wins = d_req & (~i_ren | ~last_d_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      l2_ren      <= 1'b0;
      l2_wen      <= 1'b0;
      l2_addr     <= '0;
      l2_wdata    <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      i_wait_cnt  <= '0;
      d_wait_cnt  <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (state_q == BUSY_D && i_ren) i_wait_cnt <= sat_inc(i_wait_cnt);
      if (state_q == BUSY_I && d_req) d_wait_cnt <= sat_inc(d_wait_cnt);
      case (state_q)
        IDLE: if (i_ren | d_req) begin
          state_q  <= d_wins ? BUSY_D : BUSY_I;
          last_d_q <= d_wins;
          l2_addr  <= d_wins ? d_addr : i_addr;
          // read+write together is a write-back
          l2_ren   <= ~(d_wins & d_wen);
          l2_wen   <= d_wins & d_wen;
          if (d_wins & d_wen) l2_wdata <= d_wdata;
        end
        BUSY_I, BUSY_D: if (l2_ready) begin
          state_q <= DONE;
          l2_ren  <= 1'b0;
          l2_wen  <= 1'b0;
          if (state_q == BUSY_D) begin
            d_rdata     <= l2_rdata;
            d_ready     <= 1'b1;
            d_grant_cnt <= sat_inc(d_grant_cnt);
          end else begin
            i_rdata     <= l2_rdata;
            i_ready     <= 1'b1;
            i_grant_cnt <= sat_inc(i_grant_cnt);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: randomized scoreboard bench for l2_req_arbiter
module tb_l2_req_arbiter;
  localparam int AW = 28, DW = 128, CW = 4;
  typedef struct { logic [DW-1:0] data; int cyc; } rsp_t;
  logic clk = 0, rst = 0;
  logic i_ren = 0, d_ren = 0, d_wen = 0, l2_ready = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, l2_rdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, l2_wdata;
  logic i_ready, d_ready, l2_ren, l2_wen;
  logic [AW-1:0] l2_addr;
  logic [CW-1:0] i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt;
  int tests = 0, fails = 0, cyc = 0, p_req = 100, n_i = 0, n_d = 0, seen_i = 0, seen_d = 0, lat = -1, n0 = 0;
  bit run_i = 0, run_d = 0, chk_en = 0;
  rsp_t exp_i[$], exp_d[$];
  rsp_t e, r;
  logic [CW-1:0] mi_g, md_g, mi_w, md_w;
  logic [DW-1:0] m_drd, m_ird;
  logic [AW-1:0] a_q;
  bit m_last_d, act, act_q, gd, pi, pd, exp_start;
  l2_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .l2_ren(l2_ren), .l2_wen(l2_wen), .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_ready(l2_ready),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
  task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, x, cyc);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, DW'({i_ready, d_ready, l2_ren, l2_wen}), '0);
    chk({tag, "_l2_addr"}, DW'(l2_addr), '0);
    chk({tag, "_l2_wdata"}, l2_wdata, '0);
    chk({tag, "_i_rdata"}, i_rdata, '0);
    chk({tag, "_d_rdata"}, d_rdata, '0);
    chk({tag, "_counters"}, DW'({i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt}), '0);
  endtask
  // I-cache requester: addresses with MSB clear
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin i_ren = 0; seen_i = n_i; end
    else begin
      if (i_ren && n_i != seen_i) begin i_ren = 0; seen_i = n_i; end
      if (!i_ren && run_i && $urandom_range(1, 100) <= p_req) begin
        i_addr = {1'b0, (AW-1)'($urandom)};
        i_ren = 1;
      end
    end
  end
  // D-cache requester: addresses with MSB set, random read / write / both
  initial forever begin
    @(posedge clk); #1;
    if (!rst) begin d_ren = 0; d_wen = 0; seen_d = n_d; end
    else begin
      if ((d_ren || d_wen) && n_d != seen_d) begin d_ren = 0; d_wen = 0; seen_d = n_d; end
      if (!(d_ren || d_wen) && run_d && $urandom_range(1, 100) <= p_req) begin
        int op;
        op = int'($urandom_range(0, 2));
        d_addr = {1'b1, (AW-1)'($urandom)};
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        d_ren = (op != 1);
        d_wen = (op != 0);
      end
    end
  end
  // L2 slave: random latency, plus stray ready pulses while the port is idle
  initial forever begin
    @(posedge clk); #1;
    l2_ready = 0;
    if (!rst) lat = -1;
    else if (l2_ren || l2_wen) begin
      if (lat < 0) lat = int'($urandom_range(0, 5));
      if (lat == 0) begin
        l2_rdata = {$urandom, $urandom, $urandom, $urandom};
        l2_ready = 1;
        lat = -1;
      end else lat--;
    end else if ($urandom_range(0, 7) == 0) begin
      l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      l2_ready = 1;
    end
  end
  // Monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      exp_i.delete(); exp_d.delete();
      mi_g = 0; md_g = 0; mi_w = 0; md_w = 0; m_ird = 0; m_drd = 0;
      m_last_d = 0; act_q = 0; pi = 0; pd = 0; exp_start = 0;
    end else if (chk_en) begin
      act = l2_ren | l2_wen;
      if (i_ready) begin
        if (exp_i.size() == 0) begin
          tests++; fails++;
          $display("FAIL i_ready_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = exp_i.pop_front();
          mi_g = sat(mi_g);
          m_ird = e.data;
          chk("i_rdata", i_rdata, e.data);
          chk("i_ready_cycle", DW'(cyc), DW'(e.cyc));
          chk("i_grant_cnt", DW'(i_grant_cnt), DW'(mi_g));
          chk("d_rdata_hold", d_rdata, m_drd);
          chk("wait_cnts_i", DW'({i_wait_cnt, d_wait_cnt}), DW'({mi_w, md_w}));
        end
        n_i++;
      end
      if (d_ready) begin
        if (exp_d.size() == 0) begin
          tests++; fails++;
          $display("FAIL d_ready_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = exp_d.pop_front();
          md_g = sat(md_g);
          m_drd = e.data;
          chk("d_rdata", d_rdata, e.data);
          chk("d_ready_cycle", DW'(cyc), DW'(e.cyc));
          chk("d_grant_cnt", DW'(d_grant_cnt), DW'(md_g));
          chk("i_rdata_hold", i_rdata, m_ird);
          chk("wait_cnts_d", DW'({i_wait_cnt, d_wait_cnt}), DW'({mi_w, md_w}));
        end
        n_d++;
      end
      if (exp_start) chk("grant_gap", DW'(act), DW'(1));
      if (act && !act_q) begin
        gd = l2_addr[AW-1];
        if (!(pi || pd)) begin
          tests++; fails++;
          $display("FAIL grant_no_request: got grant expected none (cycle %0d)", cyc);
        end else chk("grantee_is_d", DW'(gd), DW'((pi && pd) ? !m_last_d : pd));
        m_last_d = gd;
        chk("l2_wen", DW'(l2_wen), DW'(gd & d_wen));
        chk("l2_ren", DW'(l2_ren), DW'(gd ? !d_wen : 1'b1));
        chk("l2_addr", DW'(l2_addr), DW'(gd ? d_addr : i_addr));
        if (gd && d_wen) chk("l2_wdata", l2_wdata, d_wdata);
        a_q = l2_addr;
      end else if (act) chk("l2_addr_stable", DW'(l2_addr), DW'(a_q));
      // a response seen now is captured at the next edge and reported one cycle later
      if (act && l2_ready) begin
        r.data = l2_rdata;
        r.cyc = cyc + 1;
        if (l2_addr[AW-1]) exp_d.push_back(r); else exp_i.push_back(r);
      end
      if (act && l2_addr[AW-1] && i_ren) mi_w = sat(mi_w);
      if (act && !l2_addr[AW-1] && (d_ren || d_wen)) md_w = sat(md_w);
      exp_start = !act && !i_ready && !d_ready && (i_ren || d_ren || d_wen);
      pi = i_ren;
      pd = d_ren | d_wen;
      act_q = act;
    end
  end
  function automatic bit cond(input int w);
    case (w)
      0: return n_i >= 3 && n_d >= 3;
      1: return n_i + n_d >= 70;
      2: return !(i_ren || d_ren || d_wen || l2_ren || l2_wen);
      3: return l2_ren || l2_wen;
      default: return n_i > n0;
    endcase
  endfunction
  task automatic wait_for(input int w, input string nm);
    int k = 0;
    while (!cond(w) && k < 20000) begin @(negedge clk); k++; end
    if (!cond(w)) begin
      tests++; fails++;
      $display("FAIL timeout_%s: got no progress after %0d cycles expected condition", nm, k);
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1; chk_en = 1;
    run_i = 1; run_d = 1; p_req = 100;
    wait_for(0, "alternate");
    p_req = 35;
    wait_for(1, "random");
    run_i = 0; run_d = 0;
    wait_for(2, "drain");
    repeat (3) @(negedge clk);
    chk("drain_queues", DW'(exp_i.size() + exp_d.size()), '0);
    chk("sat_grant", DW'({i_grant_cnt, d_grant_cnt}), DW'(8'hFF));
    run_d = 1;
    wait_for(3, "d_busy");
    run_d = 0;
    @(negedge clk); #2;
    chk_en = 0; rst = 0;
    #1 chk_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1; chk_en = 1;
    n0 = n_i;
    run_i = 1;
    wait_for(4, "after_rst");
    run_i = 0;
    wait_for(2, "final_drain");
    repeat (3) @(negedge clk);
    chk("post_rst_i_grant", DW'(i_grant_cnt), DW'(n_i - n0));
    chk("post_rst_d_grant", DW'(d_grant_cnt), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
